// File: rtl/inv_pkg.sv
// Shared defaults for the inverter library primitive and its toggle counter.
package inv_pkg;

   localparam int unsigned INV_WIDTH = 1;
   localparam int unsigned INV_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
   import inv_pkg::*;
#(
   parameter int unsigned CNT_W = INV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/inverter.sv
// Bitwise inverter with a registered copy, toggle pulse and saturating toggle count.
// Build option INV_PARITY_EN adds a registered parity output y_par aligned with y_q.
module inverter
   import inv_pkg::*;
#(
   parameter int unsigned WIDTH = INV_WIDTH,
   parameter int unsigned CNT_W = INV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             tgl,
   output logic [CNT_W-1:0] tgl_cnt
`ifdef INV_PARITY_EN
   ,
   output logic             y_par
`endif
);

   logic [WIDTH-1:0] y_nxt;
   logic             tgl_nxt;

   // Combinational path is independent of clock and reset; X/Z propagate unmasked.
   assign y       = ~a;
   assign y_nxt   = ~a;
   assign tgl_nxt = (y_nxt != y_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= '0;
         tgl <= 1'b0;
      end else begin
         y_q <= y_nxt;
         tgl <= tgl_nxt;
      end
   end

   // Reset inside the counter takes priority over a same-edge toggle.
   sat_counter #(
      .CNT_W (CNT_W)
   ) u_tgl_cnt (
      .clk (clk),
      .rst (rst),
      .inc (tgl_nxt),
      .cnt (tgl_cnt)
   );

`ifdef INV_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         y_par <= 1'b0;
      end else begin
         y_par <= ^y_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_inverter.sv
// Self-checking bench for inverter: three instances (1-bit, 3-bit-counter, 8-bit)
// driven in lockstep, with a model-fed scoreboard for the registered outputs.
module tb_inverter;

   logic        clk;
   logic        rst;
   logic        a1, a_s;
   logic [7:0]  a8;
   logic        y1, ys;
   logic [7:0]  y8;
   logic        yq1, yqs;
   logic [7:0]  yq8;
   logic        t1, ts, t8;
   logic [15:0] c1, c8;
   logic [2:0]  cs;
`ifdef INV_PARITY_EN
   logic        par1, pars, par8;
`endif

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        q1;
      logic        t1;
      logic [15:0] c1;
      logic        qs;
      logic        ts;
      logic [2:0]  cs;
      logic [7:0]  q8;
      logic        t8;
      logic [15:0] c8;
      logic        p8;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic        m_q1, m_t1, m_qs, m_ts, m_t8, m_p8;
   logic [15:0] m_c1, m_c8;
   logic [2:0]  m_cs;
   logic [7:0]  m_q8;

   inverter #(.WIDTH(1), .CNT_W(16)) u_w1 (
      .clk (clk), .rst (rst), .a (a1), .y (y1), .y_q (yq1), .tgl (t1), .tgl_cnt (c1)
`ifdef INV_PARITY_EN
      , .y_par (par1)
`endif
   );

   inverter #(.WIDTH(1), .CNT_W(3)) u_sat (
      .clk (clk), .rst (rst), .a (a_s), .y (ys), .y_q (yqs), .tgl (ts), .tgl_cnt (cs)
`ifdef INV_PARITY_EN
      , .y_par (pars)
`endif
   );

   inverter #(.WIDTH(8), .CNT_W(16)) u_w8 (
      .clk (clk), .rst (rst), .a (a8), .y (y8), .y_q (yq8), .tgl (t8), .tgl_cnt (c8)
`ifdef INV_PARITY_EN
      , .y_par (par8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q1 = 1'b0; m_t1 = 1'b0; m_c1 = '0;
      m_qs = 1'b0; m_ts = 1'b0; m_cs = '0;
      m_q8 = '0;   m_t8 = 1'b0; m_c8 = '0; m_p8 = 1'b0;
   endtask

   // Drive one cycle of stimulus, predict its effect, then compare after the edge.
   task automatic step(input logic r, input logic na1, input logic nas, input logic [7:0] na8);
      exp_t e;
      exp_t g;
      @(negedge clk);
      rst = r; a1 = na1; a_s = nas; a8 = na8;
      if (r) begin
         model_reset();
      end else begin
         m_t1 = ((~na1) != m_q1);
         if (m_t1 && (m_c1 != 16'hFFFF)) m_c1 = m_c1 + 16'd1;
         m_q1 = ~na1;
         m_ts = ((~nas) != m_qs);
         if (m_ts && (m_cs != 3'd7)) m_cs = m_cs + 3'd1;
         m_qs = ~nas;
         m_t8 = ((~na8) != m_q8);
         if (m_t8 && (m_c8 != 16'hFFFF)) m_c8 = m_c8 + 16'd1;
         m_q8 = ~na8;
         m_p8 = ^(~na8);
      end
      e.q1 = m_q1; e.t1 = m_t1; e.c1 = m_c1;
      e.qs = m_qs; e.ts = m_ts; e.cs = m_cs;
      e.q8 = m_q8; e.t8 = m_t8; e.c8 = m_c8; e.p8 = m_p8;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_checks++;
      assert (sb.size() != 0) else begin
         n_err++;
         $error("FAIL scoreboard: observed empty queue expected 1 entry");
      end
      if (sb.size() != 0) begin
         g = sb.pop_front();
         check("w1_y_q",    16'(yq1), 16'(g.q1));
         check("w1_tgl",    16'(t1),  16'(g.t1));
         check("w1_cnt",    c1,       g.c1);
         check("sat_y_q",   16'(yqs), 16'(g.qs));
         check("sat_tgl",   16'(ts),  16'(g.ts));
         check("sat_cnt",   16'(cs),  16'(g.cs));
         check("w8_y_q",    16'(yq8), 16'(g.q8));
         check("w8_tgl",    16'(t8),  16'(g.t8));
         check("w8_cnt",    c8,       g.c8);
`ifdef INV_PARITY_EN
         check("w8_y_par",  16'(par8), 16'(g.p8));
`endif
      end
   endtask

   initial begin
      rst = 1'b1; a1 = 1'b0; a_s = 1'b0; a8 = 8'h00;
      model_reset();

      // Combinational path while reset is held
      a1 = 1'b1; #100;
      check("comb_y_a1", 16'(y1), 16'h0);
      $display("a=%b y=%b", a1, y1);
      a1 = 1'b0; #100;
      check("comb_y_a0", 16'(y1), 16'h1);
      $display("a=%b y=%b", a1, y1);
      a8 = 8'hA5; a_s = 1'b1; #100;
      check("comb_y8", 16'(y8), 16'h5A);
      check("comb_ys", 16'(ys), 16'h0);

      // Reset state after many edges with rst=1
      check("rst_y_q", 16'(yq1), 16'h0);
      check("rst_tgl", 16'(t1),  16'h0);
      check("rst_cnt", c1,       16'h0);
      check("rst_y8_q", 16'(yq8), 16'h0);
      check("rst_y_live", 16'(y1), 16'h1);
      step(1'b1, 1'b0, 1'b0, 8'hA5);

      // Release reset: first edge toggles, hold gives no toggle
      step(1'b0, 1'b0, 1'b0, 8'hA5);
      check("rel_y_q", 16'(yq1), 16'h1);
      check("rel_cnt", c1,       16'h1);
      check("rel_y8_q", 16'(yq8), 16'h5A);
      step(1'b0, 1'b0, 1'b1, 8'hA5);
      check("hold_tgl", 16'(t1), 16'h0);
      check("hold_cnt", c1,      16'h1);

      // Toggle every cycle to drive the 3-bit counter into saturation
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'(i % 2 == 0), 1'(i % 2 == 0), 8'($urandom_range(0, 255)));
      end
      check("sat_cnt_7", 16'(cs), 16'h7);
      step(1'b0, 1'b1, 1'b1, 8'h3C);
      check("sat_hold_7", 16'(cs), 16'h7);

      // Reset mid-run with inputs toggling: reset wins, no increment
      step(1'b1, 1'b0, 1'b0, 8'hC3);
      check("mid_rst_cnt", c1, 16'h0);
      check("mid_rst_y", 16'(y1), 16'h1);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      step(1'b0, 1'b0, 1'b0, 8'hFF);
      step(1'b0, 1'b0, 1'b1, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/inverter.md
Name: inverter

Overview:
- Parameterised bitwise inverter used as a library primitive.
- Zero-latency combinational output y = ~a.
- A registered copy of the inverted value.
- A saturating count of cycles on which the registered output changed, for activity/toggle monitoring.
- Single clock domain; the combinational path is independent of clock and reset.

Parameters:
- WIDTH, 1, bit width of a, y, y_q.
- CNT_W, 16, width of the toggle counter tgl_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data input.
- y  output  WIDTH  combinational inverse of a.
- y_q  output  WIDTH  registered inverse of a.
- tgl  output  1  registered pulse: y_q changed on the last clock edge.
- tgl_cnt  output  CNT_W  saturating count of tgl pulses.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- y:
  - y = ~a bitwise, purely combinational, no clock or reset dependency.
  - Valid after propagation delay only.
  - Not affected by rst.
  - Bench samples y 100 time units after changing a.
- y_q:
  - On each rising clk with rst=0, y_q <= ~a.
  - Latency 1 cycle.
  - On rst=1 at clk edge, y_q <= 0.
- tgl:
  - On rising clk with rst=0, tgl <= (~a != y_q), i.e. 1 when the new y_q value differs from the current one.
  - On rst, tgl <= 0.
  - The first edge after reset with a != all-ones gives tgl=1, because y_q was 0.
- tgl_cnt:
  - On rst, cleared to 0.
  - Otherwise increments by 1 on each edge where the tgl condition (~a != y_q) is true.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset mid-operation: all registered outputs return to 0 on the next edge; y unaffected.
- rst and toggle on the same edge: reset wins, counter does not increment.
- X/Z on a: y follows the standard bitwise ~ semantics, with no masking.

Optional Feature:
- Macro INV_PARITY_EN.
- When defined:
  - Adds output y_par (1 bit), registered.
  - y_par <= ^(~a) on each clk edge; reset value 0.
  - Latency 1, aligned with y_q.
- When undefined:
  - Port y_par does not exist.
  - All other behaviour is identical.

Decomposition:
- Shared package inv_pkg: default WIDTH/CNT_W constants.
- Sub-module sat_counter (CNT_W-wide increment with saturation and synchronous clear), instantiated once for tgl_cnt.
- Inversion and registers stay in the top module.

Test Plan:
- WIDTH=1, a=1, wait 100 -> y=0; then a=0, wait 100 -> y=1. Display PASS/FAIL with a and y each step.
- Reset: rst=1 for 2 cycles with a=0 -> y_q=0, tgl=0, tgl_cnt=0, y=1 (combinational path live during reset).
- Registered path: release rst, a=0 -> after 1 edge y_q=1, tgl=1, tgl_cnt=1. Hold a=0 next edge -> tgl=0, tgl_cnt=1.
- Saturation: CNT_W=3, toggle a every cycle for 10 cycles -> tgl_cnt reaches 7 and stays 7.
- WIDTH=8: a=8'hA5 -> y=8'h5A immediately, y_q=8'h5A after 1 edge. With INV_PARITY_EN defined, y_par=0 (even number of 1s in 8'h5A).
- Reset mid-run with a toggling -> on the edge with rst=1: y_q=0, tgl=0, tgl_cnt=0, no increment on that edge.
